// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the fetch PC, issuing in-order word reads and
// buffering returned words with their addresses for decode. Optional macro FETCH_STATS_EN adds stall_cycles.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic        redirect,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0] stall_cycles,
`endif
  output logic [31:0] fetch_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   target_pc, rsp_pc;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   hold_data_q, hold_pc_q;
  logic          accept, push, pop, rsp_drop;

  assign target_pc   = pc_in & 32'hFFFF_FFFC;
  assign mem_addr    = pc_q;
  assign fetch_pc    = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_data  = instr_valid ? data_mem[rd_ptr_q] : hold_data_q;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : hold_pc_q;

  // Requests are contiguous since the last redirect, so the oldest live request
  // sits outst_q words behind the fetch PC; this replaces an explicit address queue.
  assign rsp_pc = pc_q - (32'(outst_q) << 2);

  always_comb begin
    mem_req_valid = (state_q == RUN) && !redirect &&
                    (({1'b0, count_q} + {1'b0, outst_q}) < CREDITS);
    accept   = mem_req_valid && mem_req_ready;
    rsp_drop = redirect || (disc_q != '0);
    push     = mem_rsp_valid && !rsp_drop;
    pop      = instr_valid && instr_ready;
  end

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q;
    disc_d  = disc_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (redirect) begin
      pc_d    = target_pc;
      outst_d = '0;
      // A response landing this cycle retires one in-flight read, stale or live.
      disc_d  = disc_q + outst_q - CW'(mem_rsp_valid);
      count_d = '0;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      outst_d = outst_q + CW'(accept) - CW'(push);
      if (mem_rsp_valid && (disc_q != '0)) disc_d = disc_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redirect && (disc_d != '0)) state_d = DRAIN;
      DRAIN:   if (!redirect && (disc_q == '0)) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      outst_q     <= '0;
      disc_q      <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hold_data_q <= '0;
      hold_pc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      count_q <= count_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_q + AW'(push);
        rd_ptr_q <= rd_ptr_q + AW'(pop);
      end
      if (instr_valid) begin
        hold_data_q <= instr_data;
        hold_pc_q   <= instr_pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rsp_data;
      pc_mem[wr_ptr_q]   <= rsp_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic stall_inc;
  assign stall_inc = (state_q == DRAIN) ||
                     ((state_q == RUN) && mem_req_valid && !mem_req_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall_inc && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-based
// transaction model and a latency-randomized instruction memory.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        redirect;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [31:0] fetch_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pc_in         (pc_in),
    .redirect      (redirect),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
`ifdef FETCH_STATS_EN
    .stall_cycles  (stall_cycles),
`endif
    .fetch_pc      (fetch_pc)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  // memory side
  mreq_t       memq[$];
  bit          rsp_hold;
  int unsigned rsp_pct;
  int unsigned fixed_lat;

  // reference model
  bit          m_started;
  bit          m_drain;
  logic [31:0] m_pc;
  logic [31:0] m_inflight[$];
  logic [63:0] m_fifo[$];
  logic [63:0] m_last;
  int unsigned m_discard;
  logic [31:0] m_stall;

  logic [31:0] seen_pc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_drain   = 1'b0;
    m_pc      = RESET_PC;
    m_inflight.delete();
    m_fifo.delete();
    m_last    = '0;
    m_discard = 0;
    m_stall   = '0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_valid"},   32'(mem_req_valid), 32'd0);
    chk({pfx, "_mem_addr"},    mem_addr,           RESET_PC);
    chk({pfx, "_fetch_pc"},    fetch_pc,           RESET_PC);
    chk({pfx, "_instr_valid"}, 32'(instr_valid),   32'd0);
    chk({pfx, "_instr_data"},  instr_data,         32'd0);
    chk({pfx, "_instr_pc"},    instr_pc,           32'd0);
`ifdef FETCH_STATS_EN
    chk({pfx, "_stall"},       stall_cycles,       32'd0);
`endif
  endtask

  // One clock cycle: memory drives its response, outputs are checked mid-cycle,
  // then memory and model advance over the rising edge.
  task automatic step();
    logic        exp_rv, acc, pop;
    logic [31:0] a;
    logic [63:0] head;
    int unsigned lat, disc_before;
    if (!rsp_hold && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(0, 99) < rsp_pct) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    @(negedge clock);
    exp_rv = m_started && !m_drain && !redirect && (m_fifo.size() + m_inflight.size() < DEPTH);
    head   = (m_fifo.size() > 0) ? m_fifo[0] : m_last;
    chk("req_valid",   32'(mem_req_valid), 32'(exp_rv));
    chk("mem_addr",    mem_addr,           m_pc);
    chk("fetch_pc",    fetch_pc,           m_pc);
    chk("instr_valid", 32'(instr_valid),   32'(m_fifo.size() > 0));
    chk("instr_pc",    instr_pc,           head[63:32]);
    chk("instr_data",  instr_data,         head[31:0]);
`ifdef FETCH_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    if (mem_rsp_valid) void'(memq.pop_front());
    if (mem_req_valid && mem_req_ready) begin
      lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
      memq.push_back('{addr: mem_addr, due: cyc + lat});
    end
    if (instr_valid && instr_ready) seen_pc.push_back(instr_pc);

    acc         = exp_rv && mem_req_ready;
    pop         = (m_fifo.size() > 0) && instr_ready;
    disc_before = m_discard;
    if (m_started && (m_drain || (exp_rv && !mem_req_ready)) && (m_stall != 32'hFFFF_FFFF))
      m_stall = m_stall + 32'd1;
    if (m_fifo.size() > 0) m_last = m_fifo[0];
    if (pop) void'(m_fifo.pop_front());
    if (mem_rsp_valid) begin
      if (m_discard > 0) m_discard--;
      else begin
        a = m_inflight.pop_front();
        if (!redirect) m_fifo.push_back({a, mem_word(a)});
      end
    end
    if (redirect) begin
      m_discard += m_inflight.size();
      m_inflight.delete();
      m_fifo.delete();
      m_pc = {pc_in[31:2], 2'b00};
    end else if (acc) begin
      m_inflight.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (!m_started) m_started = 1'b1;
    else if (redirect) begin
      if (!m_drain) m_drain = (m_discard > 0);
    end else if (m_drain && disc_before == 0) m_drain = 1'b0;

    @(posedge clock);
    #1;
    cyc++;
    redirect = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    reset_n       = 1'b0;
    redirect      = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    memq.delete();
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0, n;
    bit got;
`ifdef FETCH_STATS_EN
    logic [31:0] s0;
`endif
    reset_n       = 1'b0;
    redirect      = 1'b0;
    pc_in         = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    instr_ready   = 1'b0;
    rsp_hold      = 1'b0;
    rsp_pct       = 100;
    fixed_lat     = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("rst_init");
    reset_n = 1'b1;

    // full-rate streaming, 1-cycle memory
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    seen_pc.delete();
    repeat (5) step();
    n0 = seen_pc.size();
    repeat (20) step();
    chk("t2_rate", seen_pc.size() - n0, 32'd20);
    chk("t2_first_pc", (seen_pc.size() > 0) ? seen_pc[0] : 32'hDEAD_BEEF, 32'd0);

    // decode stalled: FIFO fills and requests stop
    instr_ready = 1'b0;
    repeat (12) step();
    chk("t3_stop", 32'(mem_req_valid), 32'd0);
    chk("t3_full", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    seen_pc.delete();
    repeat (8) step();
    chk("t3_drained", 32'(seen_pc.size() >= 4), 32'd1);

    // redirect with three reads outstanding
    mem_req_ready = 1'b0;
    repeat (8) step();
    rsp_hold      = 1'b1;
    mem_req_ready = 1'b1;
    n = 0;
    while (m_inflight.size() < 3 && n < 10) begin
      step();
      n++;
    end
    chk("t4_outstanding", 32'(m_inflight.size()), 32'd3);
    redirect = 1'b1;
    pc_in    = 32'h0000_0103;
    step();
    chk("t4_fetch_pc", fetch_pc, 32'h0000_0100);
    chk("t4_drain_noreq", 32'(mem_req_valid), 32'd0);
    rsp_hold = 1'b0;
    seen_pc.delete();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = (seen_pc.size() > 0);
    end
    chk("t4_got_word", 32'(got), 32'd1);
    if (got) chk("t4_first_pc", seen_pc[0], 32'h0000_0100);

    // address wrap
    redirect = 1'b1;
    pc_in    = 32'hFFFF_FFF9;
    step();
    seen_pc.delete();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = (seen_pc.size() >= 3);
    end
    chk("wrap_got_words", 32'(got), 32'd1);
    if (got) begin
      chk("wrap_pc0", seen_pc[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", seen_pc[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", seen_pc[2], 32'h0000_0000);
    end

    // reset in the middle of traffic
    do_reset();
    chk("t1_idle_noreq", 32'(mem_req_valid), 32'd0);
    step();
    chk("t1_run_req", 32'(mem_req_valid), 32'd1);
    chk("t1_addr", mem_addr, 32'd0);

`ifdef FETCH_STATS_EN
    mem_req_ready = 1'b0;
    repeat (6) step();
    s0 = stall_cycles;
    repeat (10) step();
    chk("t6_stall10", stall_cycles - s0, 32'd10);
    mem_req_ready = 1'b1;
`endif

    // randomized traffic with redirects and occasional resets
    fixed_lat = 0;
    rsp_pct   = 70;
    for (int i = 0; i < 600; i++) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        if (m_started && $urandom_range(0, 29) == 0) begin
          redirect = 1'b1;
          pc_in    = $urandom;
        end
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
